pipe_regs_fd: RTL
=================

# pipe_regs_fd

Pipeline-state block for the 5-stage MIPS core: PC register, IF/ID register and ID/EX register, the stages that carry out the stall, flush and redirect requests produced by the hazard logic and branch comparator. It sits between instruction memory/decode and the execute stage. It also keeps saturating stall and flush event counters for performance debug.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CNT_W, 16, width of the event counters

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- StallF  in  1  hold PC
- StallD  in  1  hold IF/ID
- FlushE  in  1  clear ID/EX (bubble insert)
- PCSrcD  in  1  branch taken in Decode: redirect PC, flush IF/ID
- PCBranchD  in  32  branch target
- InstrF  in  32  instruction fetched at PCF
- CtrlD  in  8  {RegWrite, MemtoReg, MemWrite, ALUControl[2:0], ALUSrc, RegDst}
- RD1D, RD2D, SignImmD  in  32 each  decode operands
- RsD, RtD, RdD  in  5 each  register specifiers
- PCF  out  32  fetch PC
- InstrD, PCPlus4D  out  32 each  IF/ID contents
- ValidD  out  1  IF/ID holds a real instruction
- CtrlE  out  8; RD1E, RD2E, SignImmE  out  32; RsE, RtE, RdE  out  5  ID/EX contents
- ValidE  out  1  ID/EX holds a real instruction
- StallCnt, FlushCnt  out  CNT_W  event counters

## Operation
- Reset (rst_n low, asynchronous assert): PCF = RESET_PC; every other output 0 (InstrD = 0 is sll $0 = nop; CtrlE = 0 means no register or memory write). Deassertion is sampled at the next rising edge; the first fetch is at RESET_PC.
- PC, priority order: StallF → hold; else PCSrcD → PCBranchD; else PCF + 4. The addition wraps modulo 2^32 (32'hFFFF_FFFC → 0).
- IF/ID, priority order: StallD → hold all fields; else PCSrcD → flush (InstrD = 0, PCPlus4D = 0, ValidD = 0); else load InstrF, PCF + 4, ValidD = 1.
- Stall has priority over PCSrcD: while the branch is stalled its operands are stale, so the redirect is taken only in the cycle StallD is low.
- ID/EX has no stall. FlushE → all fields 0, ValidE = 0. Otherwise load all D-stage inputs, and ValidE takes ValidD.
- StallF = 1 with StallD = 0 is legal: the PC holds and IF/ID reloads the same instruction.
- StallCnt increments on every cycle with StallF = 1.
- FlushCnt increments on every cycle with PCSrcD = 1 and StallD = 0 (an IF/ID flush). FlushE does not count.
- Both counters saturate at all-ones and do not wrap. Both clear only on reset.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Latency: one cycle per stage. InstrF sampled at edge n appears on InstrD after edge n; the matching operands appear on the E outputs after edge n+1.
- Control inputs are sampled at the rising edge only. A one-cycle pulse affects exactly one update.
- Reset assertion mid-operation clears state immediately, without a clock edge. Any in-flight instructions are discarded.

## Test plan
- Reset then free-run, RESET_PC = 0x400: PCF steps 0x400, 0x404, 0x408. InstrD lags InstrF by one cycle. ValidD = 1 from the second edge. StallCnt = FlushCnt = 0.
- Load-use stall: StallF = StallD = FlushE = 1 for one cycle at PCF = 0x40C. Required: PCF and InstrD hold, the next ValidE = 0 and CtrlE = 0, StallCnt = 1. Execution resumes at 0x410 the following cycle.
- Taken branch: PCSrcD = 1, PCBranchD = 0x500. Required: next PCF = 0x500, InstrD = 0, ValidD = 0, FlushCnt = 1. One cycle later, ValidE = 0.
- Branch with operand stall: StallD = StallF = 1 and PCSrcD = 1 for two cycles, then PCSrcD = 1 alone for one cycle. Required: no redirect and no flush during the stall. The redirect happens on the third edge. Final counts are StallCnt = 2 and FlushCnt = 1.
- Wrap and saturate (CNT_W = 4): PCF at 0xFFFF_FFFC advances to 0. Holding StallF for 20 cycles gives StallCnt = 15 (saturated).
- Asynchronous reset asserted mid-cycle during a stall: outputs return to reset values before the next edge.

Source files
------------

// File: rtl/pipe_regs_fd.sv
// -----------------------------------------------------------------------------
// pipe_regs_fd
//
// Pipeline-state block for a 5-stage MIPS core. It holds:
//   - the fetch PC register,
//   - the IF/ID pipeline register,
//   - the ID/EX pipeline register.
// It applies the stall, flush and redirect requests that come from the hazard
// unit and the Decode-stage branch comparator. Two saturating event counters
// (stall cycles, IF/ID flushes) are kept for performance debug.
//
// Parameters:
//   RESET_PC  PC value loaded on reset
//   CNT_W     width of the stall / flush event counters
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   StallF, StallD              hold PC / hold IF/ID
//   FlushE                      clear ID/EX (bubble insert)
//   PCSrcD, PCBranchD           taken branch in Decode and its target
//   InstrF                      instruction fetched at PCF
//   CtrlD, RD1D, RD2D, SignImmD Decode control word and operands
//   RsD, RtD, RdD               Decode register specifiers
//   PCF                         fetch PC
//   InstrD, PCPlus4D, ValidD    IF/ID contents
//   CtrlE, RD1E, RD2E, SignImmE,
//   RsE, RtE, RdE, ValidE       ID/EX contents
//   StallCnt, FlushCnt          saturating event counters
//
// Every output comes straight from a flop; no input reaches an output
// without passing through a register.
// -----------------------------------------------------------------------------
module pipe_regs_fd #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             StallF,
   input  logic             StallD,
   input  logic             FlushE,
   input  logic             PCSrcD,
   input  logic [31:0]      PCBranchD,
   input  logic [31:0]      InstrF,
   input  logic [7:0]       CtrlD,
   input  logic [31:0]      RD1D,
   input  logic [31:0]      RD2D,
   input  logic [31:0]      SignImmD,
   input  logic [4:0]       RsD,
   input  logic [4:0]       RtD,
   input  logic [4:0]       RdD,
   output logic [31:0]      PCF,
   output logic [31:0]      InstrD,
   output logic [31:0]      PCPlus4D,
   output logic             ValidD,
   output logic [7:0]       CtrlE,
   output logic [31:0]      RD1E,
   output logic [31:0]      RD2E,
   output logic [31:0]      SignImmE,
   output logic [4:0]       RsE,
   output logic [4:0]       RtE,
   output logic [4:0]       RdE,
   output logic             ValidE,
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] FlushCnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Sequential PC; the 32-bit add wraps naturally at 2^32.
   logic [31:0] pc_plus4;
   assign pc_plus4 = PCF + 32'd4;

   // An IF/ID flush only happens when the branch is actually resolved, i.e.
   // when Decode is not stalled (stale operands while stalled).
   logic flush_d;
   assign flush_d = PCSrcD && !StallD;

   // ---------------------------------------------------------------- PC
   // Stall wins over redirect: a stalled branch must not redirect yet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         PCF <= RESET_PC;
      end else if (!StallF) begin
         PCF <= PCSrcD ? PCBranchD : pc_plus4;
      end
   end

   // ---------------------------------------------------------------- IF/ID
   // A cleared IF/ID (InstrD = 0) decodes as sll $0 = nop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         InstrD   <= '0;
         PCPlus4D <= '0;
         ValidD   <= 1'b0;
      end else if (!StallD) begin
         if (PCSrcD) begin
            InstrD   <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
         end else begin
            InstrD   <= InstrF;
            PCPlus4D <= pc_plus4;
            ValidD   <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------- ID/EX
   // No stall input: the hazard unit turns a Decode stall into a bubble here
   // via FlushE. A zero control word performs no register or memory write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         CtrlE    <= '0;
         RD1E     <= '0;
         RD2E     <= '0;
         SignImmE <= '0;
         RsE      <= '0;
         RtE      <= '0;
         RdE      <= '0;
         ValidE   <= 1'b0;
      end else if (FlushE) begin
         CtrlE    <= '0;
         RD1E     <= '0;
         RD2E     <= '0;
         SignImmE <= '0;
         RsE      <= '0;
         RtE      <= '0;
         RdE      <= '0;
         ValidE   <= 1'b0;
      end else begin
         CtrlE    <= CtrlD;
         RD1E     <= RD1D;
         RD2E     <= RD2D;
         SignImmE <= SignImmD;
         RsE      <= RsD;
         RtE      <= RtD;
         RdE      <= RdD;
         ValidE   <= ValidD;
      end
   end

   // ---------------------------------------------------------------- counters
   // Saturating: once all-ones they stick until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         StallCnt <= '0;
         FlushCnt <= '0;
      end else begin
         if (StallF && (StallCnt != CNT_MAX)) begin
            StallCnt <= StallCnt + CNT_ONE;
         end
         if (flush_d && (FlushCnt != CNT_MAX)) begin
            FlushCnt <= FlushCnt + CNT_ONE;
         end
      end
   end

endmodule
